// File: rtl/chunk_transfer_ctrl_if.sv
// Signal bundle between the chunk transfer sequencer, the DDR streams, the BRAM cache port and the solver.
interface chunk_transfer_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              start;
  logic              compute_done;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;
  logic              chunk_transfer_ready;
  logic              chunk_compute_ready;
  logic [ADDR_W-1:0] DDR_addr;
  logic              cache_wen;
  logic [DATA_W-1:0] cache_null_in, cache_n_in, cache_ne_in, cache_e_in, cache_se_in;
  logic [DATA_W-1:0] cache_s_in, cache_sw_in, cache_w_in, cache_nw_in;
  logic [DATA_W-1:0] cache_null_out, cache_n_out, cache_ne_out, cache_e_out, cache_se_out;
  logic [DATA_W-1:0] cache_s_out, cache_sw_out, cache_w_out, cache_nw_out;
  logic [DATA_W-1:0] m00_axis_tdata;
  logic              m00_axis_tvalid;
  logic              m00_axis_tready;
  logic              m00_axis_tlast;
  logic              busy;
  logic              err_tlast;

  modport master (
    input  start, compute_done, s_axis_tdata, s_axis_tvalid, s_axis_tlast, m00_axis_tready,
    input  cache_null_out, cache_n_out, cache_ne_out, cache_e_out, cache_se_out,
    input  cache_s_out, cache_sw_out, cache_w_out, cache_nw_out,
    output s_axis_tready, chunk_transfer_ready, chunk_compute_ready, DDR_addr, cache_wen,
    output cache_null_in, cache_n_in, cache_ne_in, cache_e_in, cache_se_in,
    output cache_s_in, cache_sw_in, cache_w_in, cache_nw_in,
    output m00_axis_tdata, m00_axis_tvalid, m00_axis_tlast, busy, err_tlast
  );

  modport slave (
    output start, compute_done, s_axis_tdata, s_axis_tvalid, s_axis_tlast, m00_axis_tready,
    output cache_null_out, cache_n_out, cache_ne_out, cache_e_out, cache_se_out,
    output cache_s_out, cache_sw_out, cache_w_out, cache_nw_out,
    input  s_axis_tready, chunk_transfer_ready, chunk_compute_ready, DDR_addr, cache_wen,
    input  cache_null_in, cache_n_in, cache_ne_in, cache_e_in, cache_se_in,
    input  cache_s_in, cache_sw_in, cache_w_in, cache_nw_in,
    input  m00_axis_tdata, m00_axis_tvalid, m00_axis_tlast, busy, err_tlast
  );
endinterface

// File: rtl/chunk_transfer_ctrl.sv
// Loads one LBM chunk from DDR into the nine direction BRAMs, hands it to the solver, then streams it back out.
// state     | meaning
// S_IDLE    | waiting for start, BRAMs unowned
// S_LOAD    | accepting inbound words, writing one cell per 9 words
// S_LDONE   | cache write of the final cell, inbound closed
// S_COMPUTE | solver owns the BRAMs
// S_UADDR   | unload: present cell address
// S_UWAIT   | unload: BRAM read latency
// S_UCAP    | unload: capture nine lanes
// S_USEND   | unload: stream nine words out
module chunk_transfer_ctrl #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int CHUNK_CELLS = 4096
) (
  input logic                 m00_axis_aclk,
  input logic                 m00_axis_aresetn,
  chunk_transfer_ctrl_if.master bus
);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CHUNK_CELLS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LDONE, S_COMPUTE, S_UADDR, S_UWAIT, S_UCAP, S_USEND
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cell_q, cell_d, addr_q, addr_d;
  logic [3:0]        word_q, word_d;
  logic [DATA_W-1:0] lane_q [9];
  logic [DATA_W-1:0] lane_d [9];
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic err_q, err_d, wen_q, wen_d, tlast_q, tlast_d;
  logic xfer_q, xfer_d, comp_q, comp_d, s_rdy_q, s_rdy_d, m_vld_q, m_vld_d, busy_q, busy_d;
  logic s_hs, m_hs, last_cell;

  assign s_hs      = bus.s_axis_tvalid & s_rdy_q;
  assign m_hs      = m_vld_q & bus.m00_axis_tready;
  assign last_cell = (cell_q == LAST_CELL);

  always_ff @(posedge m00_axis_aclk) begin
    if (!m00_axis_aresetn) begin
      state_q <= S_IDLE;
      cell_q  <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      for (int k = 0; k < 9; k++) lane_q[k] <= '0;
      tdata_q <= '0;
      {err_q, wen_q, tlast_q, xfer_q, comp_q, s_rdy_q, m_vld_q, busy_q} <= '0;
    end else begin
      state_q <= state_d;
      cell_q  <= cell_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
      tdata_q <= tdata_d;
      {err_q, wen_q, tlast_q, xfer_q, comp_q, s_rdy_q, m_vld_q, busy_q} <=
        {err_d, wen_d, tlast_d, xfer_d, comp_d, s_rdy_d, m_vld_d, busy_d};
    end
  end

  // The lane registers double as the load holding regs and the unload capture regs;
  // cache_wen is never high while unloading, so driving cache_*_in from them is harmless.
  always_comb begin
    state_d = state_q;
    cell_d  = cell_q;
    addr_d  = addr_q;
    word_d  = word_q;
    lane_d  = lane_q;
    tdata_d = tdata_q;
    tlast_d = tlast_q;
    err_d   = err_q;
    wen_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (bus.start) begin
          state_d = S_LOAD;
          cell_d  = '0;
          word_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (s_hs) begin
          lane_d[word_q] = bus.s_axis_tdata;
          if (bus.s_axis_tlast != (last_cell && (word_q == 4'd8))) err_d = 1'b1;
          if (word_q == 4'd8) begin
            word_d = '0;
            wen_d  = 1'b1;
            addr_d = cell_q;
            if (last_cell) state_d = S_LDONE;
            else           cell_d  = cell_q + 1'b1;
          end else begin
            word_d = word_q + 4'd1;
          end
        end
      end
      S_LDONE: begin
        state_d = S_COMPUTE;
        addr_d  = '0;
      end
      S_COMPUTE: begin
        if (bus.compute_done) begin
          state_d = S_UADDR;
          cell_d  = '0;
          addr_d  = '0;
        end
      end
      S_UADDR: state_d = S_UWAIT;
      S_UWAIT: state_d = S_UCAP;
      S_UCAP: begin
        lane_d[0] = bus.cache_null_out;
        lane_d[1] = bus.cache_n_out;
        lane_d[2] = bus.cache_ne_out;
        lane_d[3] = bus.cache_e_out;
        lane_d[4] = bus.cache_se_out;
        lane_d[5] = bus.cache_s_out;
        lane_d[6] = bus.cache_sw_out;
        lane_d[7] = bus.cache_w_out;
        lane_d[8] = bus.cache_nw_out;
        tdata_d   = bus.cache_null_out;
        tlast_d   = 1'b0;
        word_d    = '0;
        state_d   = S_USEND;
      end
      S_USEND: begin
        if (m_hs) begin
          if (word_q == 4'd8) begin
            tdata_d = '0;
            tlast_d = 1'b0;
            word_d  = '0;
            if (last_cell) begin
              state_d = S_IDLE;
              addr_d  = '0;
            end else begin
              cell_d  = cell_q + 1'b1;
              addr_d  = cell_q + 1'b1;
              state_d = S_UADDR;
            end
          end else begin
            word_d  = word_q + 4'd1;
            tdata_d = lane_q[word_q + 4'd1];
            tlast_d = last_cell && (word_q == 4'd7);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    xfer_d  = state_d inside {S_LOAD, S_LDONE, S_UADDR, S_UWAIT, S_UCAP, S_USEND};
    comp_d  = (state_d == S_COMPUTE);
    s_rdy_d = (state_d == S_LOAD);
    m_vld_d = (state_d == S_USEND);
    busy_d  = (state_d != S_IDLE);
  end

  assign bus.s_axis_tready        = s_rdy_q;
  assign bus.chunk_transfer_ready = xfer_q;
  assign bus.chunk_compute_ready  = comp_q;
  assign bus.DDR_addr             = addr_q;
  assign bus.cache_wen            = wen_q;
  assign bus.cache_null_in        = lane_q[0];
  assign bus.cache_n_in           = lane_q[1];
  assign bus.cache_ne_in          = lane_q[2];
  assign bus.cache_e_in           = lane_q[3];
  assign bus.cache_se_in          = lane_q[4];
  assign bus.cache_s_in           = lane_q[5];
  assign bus.cache_sw_in          = lane_q[6];
  assign bus.cache_w_in           = lane_q[7];
  assign bus.cache_nw_in          = lane_q[8];
  assign bus.m00_axis_tdata       = tdata_q;
  assign bus.m00_axis_tvalid      = m_vld_q;
  assign bus.m00_axis_tlast       = tlast_q;
  assign bus.busy                 = busy_q;
  assign bus.err_tlast            = err_q;
endmodule

// File: tb/tb_chunk_transfer_ctrl.sv
// Directed bench for chunk_transfer_ctrl with a 4-cell chunk and a behavioural BRAM behind the cache port.
module tb_chunk_transfer_ctrl;
  localparam int CELLS = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  chunk_transfer_ctrl_if #(.ADDR_W(12), .DATA_W(16)) bus ();

  chunk_transfer_ctrl #(.ADDR_W(12), .DATA_W(16), .CHUNK_CELLS(CELLS)) dut (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rstn),
    .bus              (bus)
  );

  int checks = 0;
  int errors = 0;
  int wen_cnt = 0;
  int out_cnt = 0;
  int          exp_addr_q[$];
  logic [15:0] exp_wr_q[$];
  logic [16:0] exp_out_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // BRAM model: nine lanes, synchronous write, one-cycle registered read
  logic [15:0] mem [CELLS][9];
  logic [15:0] bram_out [9];
  logic [15:0] c_in [9];
  assign c_in = '{bus.cache_null_in, bus.cache_n_in, bus.cache_ne_in, bus.cache_e_in,
                  bus.cache_se_in, bus.cache_s_in, bus.cache_sw_in, bus.cache_w_in, bus.cache_nw_in};
  always @(posedge clk) begin
    for (int k = 0; k < 9; k++) begin
      if (bus.cache_wen) mem[bus.DDR_addr[1:0]][k] <= c_in[k];
      bram_out[k] <= mem[bus.DDR_addr[1:0]][k];
    end
  end
  assign bus.cache_null_out = bram_out[0];
  assign bus.cache_n_out    = bram_out[1];
  assign bus.cache_ne_out   = bram_out[2];
  assign bus.cache_e_out    = bram_out[3];
  assign bus.cache_se_out   = bram_out[4];
  assign bus.cache_s_out    = bram_out[5];
  assign bus.cache_sw_out   = bram_out[6];
  assign bus.cache_w_out    = bram_out[7];
  assign bus.cache_nw_out   = bram_out[8];

  always @(negedge clk) begin
    if (rstn && bus.cache_wen) begin
      wen_cnt++;
      if (exp_addr_q.size() == 0) chk("wen_unexpected", exp_addr_q.size(), 1);
      else begin
        chk("wen_addr", bus.DDR_addr, exp_addr_q.pop_front());
        for (int k = 0; k < 9; k++) chk("wen_lane", c_in[k], exp_wr_q.pop_front());
      end
    end
  end

  logic        stalled = 1'b0;
  logic [15:0] stall_data;
  logic        stall_last;
  always @(negedge clk) begin
    if (rstn && bus.m00_axis_tvalid) begin
      if (stalled) begin
        chk("stall_data", bus.m00_axis_tdata, stall_data);
        chk("stall_last", bus.m00_axis_tlast, stall_last);
      end
      if (bus.m00_axis_tready) begin
        if (exp_out_q.size() == 0) chk("out_unexpected", exp_out_q.size(), 1);
        else begin
          logic [16:0] e;
          e = exp_out_q.pop_front();
          chk("out_data", bus.m00_axis_tdata, e[15:0]);
          chk("out_last", bus.m00_axis_tlast, e[16]);
        end
        out_cnt++;
        stalled = 1'b0;
      end else begin
        stalled    = 1'b1;
        stall_data = bus.m00_axis_tdata;
        stall_last = bus.m00_axis_tlast;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic drive_load(input bit gaps, input int last_pos, input int cd_at);
    bit hs;
    int budget;
    for (int c = 0; c < CELLS; c++) begin
      exp_addr_q.push_back(c);
      for (int k = 0; k < 9; k++) exp_wr_q.push_back(16'(16'h0100 + 9 * c + k));
    end
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int i = 0; i < 9 * CELLS; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          bus.s_axis_tvalid = 1'b0;
          @(posedge clk); #1;
        end
      end
      bus.s_axis_tdata  = 16'(16'h0100 + i);
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tlast  = (i == last_pos);
      bus.compute_done  = (i == cd_at);
      budget = 0;
      do begin
        @(negedge clk) hs = bus.s_axis_tready;
        @(posedge clk); #1 bus.compute_done = 1'b0;
        budget++;
      end while (!hs && budget < 50);
      if (!hs) begin
        chk("load_hs_timeout", hs, 1);
        bus.s_axis_tvalid = 1'b0;
        return;
      end
      if (last_pos != 9 * CELLS - 1 && i == last_pos - 1) chk("err_tlast_before", bus.err_tlast, 0);
      if (last_pos != 9 * CELLS - 1 && i == last_pos)     chk("err_tlast_after", bus.err_tlast, 1);
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_compute(input int wen_base);
    int budget = 0;
    while (!bus.chunk_compute_ready && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("compute_ready", bus.chunk_compute_ready, 1);
    chk("compute_xfer_ready", bus.chunk_transfer_ready, 0);
    chk("compute_s_tready", bus.s_axis_tready, 0);
    chk("compute_addr", bus.DDR_addr, 0);
    chk("compute_busy", bus.busy, 1);
    chk("load_wen_count", wen_cnt - wen_base, CELLS);
  endtask

  task automatic push_unload_and_go();
    for (int i = 0; i < 9 * CELLS; i++) exp_out_q.push_back({i == 9 * CELLS - 1, 16'(16'h0100 + i)});
    @(posedge clk); #1 bus.compute_done = 1'b1;
    @(posedge clk); #1 bus.compute_done = 1'b0;
  endtask

  task automatic unload_all();
    int base = out_cnt;
    int budget = 0;
    push_unload_and_go();
    while (bus.busy && budget < 2000) begin
      @(posedge clk); #1 bus.m00_axis_tready = 1'($urandom_range(0, 1));
      budget++;
    end
    bus.m00_axis_tready = 1'b0;
    chk("unload_word_count", out_cnt - base, 9 * CELLS);
    chk("unload_idle_busy", bus.busy, 0);
    chk("unload_idle_tvalid", bus.m00_axis_tvalid, 0);
    chk("unload_idle_xfer", bus.chunk_transfer_ready, 0);
    chk("unload_idle_addr", bus.DDR_addr, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk(tag, |{bus.s_axis_tready, bus.chunk_transfer_ready, bus.chunk_compute_ready, bus.DDR_addr,
               bus.cache_wen, bus.cache_null_in, bus.cache_n_in, bus.cache_ne_in, bus.cache_e_in,
               bus.cache_se_in, bus.cache_s_in, bus.cache_sw_in, bus.cache_w_in, bus.cache_nw_in,
               bus.m00_axis_tdata, bus.m00_axis_tvalid, bus.m00_axis_tlast, bus.busy, bus.err_tlast}, 0);
  endtask

  task automatic check_bram();
    for (int c = 0; c < CELLS; c++)
      for (int k = 0; k < 9; k++) chk("bram_word", mem[c][k], 16'(16'h0100 + 9 * c + k));
  endtask

  initial begin
    int base;
    int budget;
    bus.start = 1'b0;
    bus.compute_done = 1'b0;
    bus.s_axis_tdata = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0;
    bus.m00_axis_tready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset_outputs");
    chk("reset_busy", bus.busy, 0);
    rstn = 1'b1;

    // clean back-to-back load
    base = wen_cnt;
    drive_load(1'b0, 9 * CELLS - 1, -1);
    wait_compute(base);
    chk("load1_err_tlast", bus.err_tlast, 0);
    chk("load1_cell1_ne", mem[1][2], 16'h010B);
    check_bram();

    // start while computing is ignored
    base = wen_cnt;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("start_in_compute_ready", bus.chunk_compute_ready, 1);
    chk("start_in_compute_tready", bus.s_axis_tready, 0);
    chk("start_in_compute_wen", wen_cnt - base, 0);

    unload_all();

    // load with random gaps and a stray compute_done mid-load
    base = wen_cnt;
    drive_load(1'b1, 9 * CELLS - 1, 10);
    wait_compute(base);
    chk("load2_err_tlast", bus.err_tlast, 0);
    check_bram();

    // reset in the middle of unloading cell 2
    push_unload_and_go();
    budget = 0;
    while (!(bus.DDR_addr == 12'd2 && bus.m00_axis_tvalid) && budget < 2000) begin
      @(posedge clk); #1 bus.m00_axis_tready = 1'($urandom_range(0, 1));
      budget++;
    end
    chk("reach_unload_cell2", bus.DDR_addr, 2);
    bus.m00_axis_tready = 1'b0;
    rstn = 1'b0;
    @(posedge clk); #1;
    check_outputs_zero("midreset_outputs");
    chk("midreset_busy", bus.busy, 0);
    chk("midreset_tvalid", bus.m00_axis_tvalid, 0);
    rstn = 1'b1;
    exp_out_q.delete();

    // tlast early on word 17 and missing on the final word
    base = wen_cnt;
    drive_load(1'b0, 17, -1);
    wait_compute(base);
    chk("load3_err_tlast_hold", bus.err_tlast, 1);
    check_bram();

    unload_all();
    chk("err_tlast_held_idle", bus.err_tlast, 1);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    chk("err_tlast_cleared_by_start", bus.err_tlast, 0);
    chk("restart_busy", bus.busy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=%0d expected=finish", checks);
    $fatal(1, "timeout");
  end
endmodule
